// File: rtl/i_mem_line_fill.sv
// Line-fill engine: fetches an aligned 16-byte instruction line as four sequential
// 32-bit reads, assembles it into 128 bits and strobes line_valid (or fill_err on a watchdog abort).
module i_mem_line_fill #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IREQ,
  input  logic [ADDR_W-1:0] IADDR,
  output logic [127:0]      line_data,
  output logic [ADDR_W-1:0] line_addr,
  output logic              line_valid,
  output logic              busy,
  output logic              fill_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ABORT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [7:0]        wdog_q, wdog_d;
  logic [127:0]      line_data_q, line_data_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              line_valid_q, line_valid_d;
  logic              fill_err_q, fill_err_d;
  logic              busy_q, busy_d;

  // The low nibble of the miss address never matters: fills are always line aligned.
  logic unused_iaddr_bits;
  assign unused_iaddr_bits = ^IADDR[3:0];

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wdog_d       = wdog_q;
    line_data_d  = line_data_q;
    line_addr_d  = line_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = 1'b0;
    line_valid_d = 1'b0;
    fill_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (IREQ) begin
          line_addr_d = {IADDR[ADDR_W-1:4], 4'b0000};
          mem_addr_d  = {IADDR[ADDR_W-1:4], 4'b0000};
          beat_d      = 2'd0;
          wdog_d      = 8'd0;
          mem_req_d   = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        mem_req_d = 1'b1;
        if (mem_ack) begin
          line_data_d[{beat_q, 5'b00000} +: 32] = mem_rdata;
          wdog_d = 8'd0;
          if (beat_q == 2'd3) begin
            mem_req_d    = 1'b0;
            line_valid_d = 1'b1;
            state_d      = DONE;
          end else begin
            beat_d     = beat_q + 2'd1;
            // Beat index sits directly in bits [3:2]; the base is line aligned so no carry.
            mem_addr_d = {line_addr_q[ADDR_W-1:4], beat_d, 2'b00};
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_q == 8'(TIMEOUT - 1)) begin
            mem_req_d  = 1'b0;
            fill_err_d = 1'b1;
            state_d    = ABORT;
          end
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      wdog_q       <= 8'd0;
      line_data_q  <= '0;
      line_addr_q  <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      line_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wdog_q       <= wdog_d;
      line_data_q  <= line_data_d;
      line_addr_q  <= line_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      line_valid_q <= line_valid_d;
      fill_err_q   <= fill_err_d;
      busy_q       <= busy_d;
    end
  end

  assign line_data  = line_data_q;
  assign line_addr  = line_addr_q;
  assign line_valid = line_valid_q;
  assign busy       = busy_q;
  assign fill_err   = fill_err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_i_mem_line_fill.sv
// Directed bench for i_mem_line_fill: basic, stalled, ignored-input, timeout,
// back-to-back and mid-fill reset scenarios with hand-computed expectations.
module tb_i_mem_line_fill;

  logic         clk;
  logic         rst;
  logic         IREQ;
  logic [31:0]  IADDR;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_valid;
  logic         busy;
  logic         fill_err;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  i_mem_line_fill #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .IREQ       (IREQ),
    .IADDR      (IADDR),
    .line_data  (line_data),
    .line_addr  (line_addr),
    .line_valid (line_valid),
    .busy       (busy),
    .fill_err   (fill_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then advance past the next rising edge so outputs can be sampled.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic ack, input logic [31:0] rdata);
    IREQ      = ireq;
    IADDR     = iaddr;
    mem_ack   = ack;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1; IREQ = 1'b0; IADDR = '0; mem_ack = 1'b0; mem_rdata = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_line_valid", line_valid, 0);
    checkOutput("rst_fill_err", fill_err, 0);
    checkOutput("rst_line_data", line_data, 0);
    checkOutput("rst_line_addr", line_addr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Basic fill with mem_ack tied high
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 32'h0);
    checkOutput("basic_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("basic_mem_req", mem_req, 1);
      checkOutput("basic_mem_addr", mem_addr, 32'h1230 + 4 * k);
      checkOutput("basic_no_valid", line_valid, 0);
      applyStimulus(1'b0, 32'h0000_1234, 1'b1, 32'hA0 + k);
    end
    checkOutput("basic_line_valid", line_valid, 1);
    checkOutput("basic_mem_req_done", mem_req, 0);
    checkOutput("basic_busy_done", busy, 1);
    checkOutput("basic_line_data", line_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    checkOutput("basic_line_addr", line_addr, 32'h1230);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD);
    checkOutput("basic_valid_drop", line_valid, 0);
    checkOutput("basic_idle", busy, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hBEEF);
    checkOutput("idle_ack_ignored", line_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    checkOutput("idle_stays", busy, 0);

    // Stalled bus: ack on every third FETCH cycle
    applyStimulus(1'b1, 32'h0000_2040, 1'b0, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      checkOutput("stall_mem_addr", mem_addr, 32'h2040 + 4 * ((c - 1) / 3));
      checkOutput("stall_no_valid", line_valid, 0);
      checkOutput("stall_mem_req", mem_req, 1);
      if (c % 3 == 0)
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hB0 + (c / 3 - 1));
      else
        applyStimulus(1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    end
    checkOutput("stall_line_valid", line_valid, 1);
    checkOutput("stall_line_data", line_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    checkOutput("stall_line_addr", line_addr, 32'h2040);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("stall_valid_drop", line_valid, 0);
    checkOutput("stall_idle", busy, 0);

    // IREQ dropped and IADDR changed mid-fill
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("chg_mem_addr", mem_addr, 32'h1230 + 4 * k);
      applyStimulus(1'b0, 32'h0000_5000, 1'b1, 32'hC0 + k);
    end
    checkOutput("chg_line_valid", line_valid, 1);
    checkOutput("chg_line_addr", line_addr, 32'h1230);
    checkOutput("chg_line_data", line_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    applyStimulus(1'b0, 32'h0000_5000, 1'b1, 32'h0);
    checkOutput("chg_idle", busy, 0);
    applyStimulus(1'b0, 32'h0000_5000, 1'b1, 32'h0);
    checkOutput("chg_no_refill_busy", busy, 0);
    checkOutput("chg_no_refill_req", mem_req, 0);

    // Watchdog timeout (TIMEOUT=4), mem_ack never asserted
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("tmo_no_err", fill_err, 0);
      checkOutput("tmo_busy", busy, 1);
      applyStimulus(1'b0, 32'h0000_3000, 1'b0, 32'h0);
    end
    checkOutput("tmo_fill_err", fill_err, 1);
    checkOutput("tmo_no_valid", line_valid, 0);
    checkOutput("tmo_busy_abort", busy, 1);
    checkOutput("tmo_mem_req", mem_req, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("tmo_err_drop", fill_err, 0);
    checkOutput("tmo_idle", busy, 0);
    checkOutput("tmo_data_kept", line_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});

    // Back-to-back fills with IREQ held through DONE
    applyStimulus(1'b1, 32'h0000_4000, 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_mem_req", mem_req, 1);
      applyStimulus(1'b1, 32'h0000_4000, 1'b1, 32'hD0 + k);
    end
    checkOutput("b2b_valid1", line_valid, 1);
    checkOutput("b2b_data1", line_data, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    checkOutput("b2b_gap1", mem_req, 0);
    applyStimulus(1'b1, 32'h0000_4100, 1'b1, 32'hE0);
    checkOutput("b2b_gap2", mem_req, 0);
    checkOutput("b2b_idle", busy, 0);
    applyStimulus(1'b1, 32'h0000_4100, 1'b1, 32'hE0);
    checkOutput("b2b_restart_req", mem_req, 1);
    checkOutput("b2b_restart_addr", mem_addr, 32'h4100);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hE0 + k);
    end
    checkOutput("b2b_valid2", line_valid, 1);
    checkOutput("b2b_data2", line_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    checkOutput("b2b_addr2", line_addr, 32'h4100);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a fill (beat 2)
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hF0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hF1);
    checkOutput("arst_pre_addr", mem_addr, 32'h1238);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_mem_req", mem_req, 0);
    checkOutput("arst_line_data", line_data, 0);
    checkOutput("arst_line_addr", line_addr, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hF2);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hF3);
    checkOutput("arst_post_busy", busy, 0);
    checkOutput("arst_post_req", mem_req, 0);
    checkOutput("arst_post_valid", line_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
